// File: rtl/adder_4bit.sv
// adder_4bit: registered enable-gated adder built from a full-adder carry chain, with selectable unsigned/signed overflow
module adder_4bit #(
  parameter int WIDTH = 4,
  parameter bit SIGNED_OVF = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             En,
  output logic [WIDTH-1:0] Sum,
  output logic             Overflow
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] s;
  logic ovf;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign ovf = SIGNED_OVF ? (c[WIDTH] ^ c[WIDTH-1]) : c[WIDTH];
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Sum      <= '0;
      Overflow <= 1'b0;
    end else if (En) begin
      Sum      <= s;
      Overflow <= ovf;
    end
  end
endmodule

// File: tb/tb_adder_4bit.sv
// tb_adder_4bit: scoreboard bench driving an unsigned-overflow and a signed-overflow instance with shared stimulus
module tb_adder_4bit;
  logic       Clk;
  logic       Reset;
  logic       En;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] sum_u;
  logic [3:0] sum_s;
  logic       ovf_u;
  logic       ovf_s;
  int checks;
  int errors;
  logic [3:0] m_sum;
  logic       m_ou;
  logic       m_os;
  bit         known;
  logic [5:0] sb[$];

  adder_4bit #(.WIDTH(4), .SIGNED_OVF(1'b0)) dut_u (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .En(En), .Sum(sum_u), .Overflow(ovf_u)
  );
  adder_4bit #(.WIDTH(4), .SIGNED_OVF(1'b1)) dut_s (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .En(En), .Sum(sum_s), .Overflow(ovf_s)
  );

  initial Clk = 1'b0;
  always #100 Clk = ~Clk;

  task automatic chk(input string name, input logic [3:0] gs, input logic go,
                     input logic [3:0] es, input logic eo);
    checks++;
    if (gs !== es || go !== eo) begin
      errors++;
      $display("FAIL %s: got sum=%0d ovf=%b, expected sum=%0d ovf=%b", name, gs, go, es, eo);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] a, input logic [3:0] b);
    int total;
    int sa;
    int sb_v;
    @(negedge Clk);
    Reset = r;
    En = e;
    A = a;
    B = b;
    #1;
    if (known) begin
      chk("iso_unsigned", sum_u, ovf_u, m_sum, m_ou);
      chk("iso_signed", sum_s, ovf_s, m_sum, m_os);
    end
    if (r) begin
      m_sum = 4'd0;
      m_ou = 1'b0;
      m_os = 1'b0;
      known = 1'b1;
    end else if (e) begin
      total = int'(a) + int'(b);
      sa = (a >= 8) ? int'(a) - 16 : int'(a);
      sb_v = (b >= 8) ? int'(b) - 16 : int'(b);
      m_sum = 4'(total % 16);
      m_ou = (total > 15);
      m_os = (sa + sb_v > 7) || (sa + sb_v < -8);
      known = 1'b1;
    end
    if (known) sb.push_back({m_sum, m_ou, m_os});
  endtask

  always @(posedge Clk) begin
    logic [5:0] exp;
    #1;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("out_unsigned", sum_u, ovf_u, exp[5:2], exp[1]);
      chk("out_signed", sum_s, ovf_s, exp[5:2], exp[0]);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    known = 1'b0;
    Reset = 1'b0;
    En = 1'b0;
    A = 4'd0;
    B = 4'd0;
    $monitor("%0t A=%0d B=%0d Sum=%0d Overflow=%b", $time, A, B, sum_u, ovf_u);
    step(1, 1, 4'd5, 4'd15);
    step(0, 1, 4'b0101, 4'b1111);
    step(0, 1, 4'b0101, 4'b1111);
    step(0, 0, 4'b0101, 4'b1111);
    step(0, 1, 4'd3, 4'd4);
    repeat (3) step(0, 0, 4'd15, 4'd15);
    step(0, 1, 4'd15, 4'd1);
    step(1, 1, 4'd2, 4'd2);
    step(0, 1, 4'd7, 4'd1);
    step(0, 1, 4'd5, 4'd15);
    step(0, 1, 4'd8, 4'd8);
    step(0, 0, 4'd1, 4'd1);
    step(1, 0, 4'd9, 4'd9);
    step(0, 1, 4'd9, 4'd9);
    repeat (200) step($urandom_range(15) == 0, $urandom_range(1) == 1,
                      4'($urandom_range(15)), 4'($urandom_range(15)));
    @(negedge Clk);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge Clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $monitoroff;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
